operand_fetch: RTL and testbench

//  Read-side partner of the integer register file. Accepts decoded instructions on a valid/ready port.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/operand_fetch_if.sv | 55 +++++
 rtl/operand_fetch_scoreboard.sv | 47 ++++
 rtl/operand_fetch.sv | 136 +++++++++++++
 tb/tb_operand_fetch.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-core types for the operand-fetch slice: word width,
// register index type and the hardwired-zero register.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   typedef logic [XLEN-1:0] word;
   typedef logic [4:0]      reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

   // x0 never carries a dependency; every other index can
   function automatic logic tracked(input reg_idx_t idx);
      return (idx != REG_ZERO);
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of the decode, register-file, writeback and execute-side signals
// of operand_fetch. The design uses the slave view, its environment the
// master view.
interface operand_fetch_if;
   import riscv_pkg::*;

   logic     in_valid;
   logic     in_ready;
   reg_idx_t in_rs1;
   reg_idx_t in_rs2;
   logic     in_use_rs1;
   logic     in_use_rs2;
   reg_idx_t in_rd;
   logic     in_rd_w;

   reg_idx_t rf_rs1_sel;
   reg_idx_t rf_rs2_sel;
   logic     rf_rs1_en;
   logic     rf_rs2_en;
   word      rf_rs1_data;
   word      rf_rs2_data;

   logic     wb_valid;
   reg_idx_t wb_rd;
   word      wb_data;

   logic     flush;

   logic     out_valid;
   logic     out_ready;
   word      out_rs1_val;
   word      out_rs2_val;
   reg_idx_t out_rd;

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_w,
      output in_ready,
      output rf_rs1_sel, rf_rs2_sel, rf_rs1_en, rf_rs2_en,
      input  rf_rs1_data, rf_rs2_data,
      input  wb_valid, wb_rd, wb_data, flush,
      output out_valid, out_rs1_val, out_rs2_val, out_rd,
      input  out_ready
   );

   modport master (
      output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_w,
      input  in_ready,
      input  rf_rs1_sel, rf_rs2_sel, rf_rs1_en, rf_rs2_en,
      output rf_rs1_data, rf_rs2_data,
      output wb_valid, wb_rd, wb_data, flush,
      input  out_valid, out_rs1_val, out_rs2_val, out_rd,
      output out_ready
   );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard for in-flight destinations. A set and a clear of the
// same register in one cycle leaves it busy. x0 is never marked busy.
// Three combinational query ports report the current busy state.
module opfetch_scoreboard
   import riscv_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           set_en_i,
   input  reg_idx_t       set_idx_i,
   input  logic           clr_en_i,
   input  reg_idx_t       clr_idx_i,
   input  reg_idx_t [2:0] q_idx_i,
   output logic     [2:0] busy_o
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Per-register next state: set beats clear, x0 stays clear
   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NREGS; r++) begin
         busy_d[r] = (set_en_i && tracked(set_idx_i) && (set_idx_i == reg_idx_t'(r))) ? 1'b1 :
                     (clr_en_i && tracked(clr_idx_i) && (clr_idx_i == reg_idx_t'(r))) ? 1'b0 :
                     busy_q[r];
      end
   end

   // Busy vector register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= {NREGS{1'b0}};
      end else begin
         busy_q <= busy_d;
      end
   end

   // Combinational busy lookup for the three queried indices
   always_comb begin
      busy_o = 3'b000;
      for (int i = 0; i < 3; i++) begin
         busy_o[i] = busy_q[q_idx_i[i]];
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts decoded instructions, drives the register-file
// read ports, detects RAW/WAW hazards against the scoreboard and the held
// output instruction, and registers operands for execute one cycle later.
// Optional feature macro: OPFETCH_BYPASS_EN -- forward same-cycle writeback
// data to a matching source instead of stalling one cycle.
module operand_fetch
   import riscv_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   operand_fetch_if.slave bus
);

   logic     out_valid_q, out_valid_d;
   word      out_rs1_q,   out_rs1_d;
   word      out_rs2_q,   out_rs2_d;
   reg_idx_t out_rd_q,    out_rd_d;

   logic       src1_act_s, src2_act_s;
   logic       wb1_hit_s,  wb2_hit_s;
   logic       src1_haz_s, src2_haz_s;
   logic       waw_haz_s,  held_haz_s, hazard_s;
   logic       in_ready_s, accept_s, out_fire_s;
   logic [2:0] busy_s;
   word        op1_s, op2_s;

   // A source only matters when it is used and is not x0
   assign src1_act_s = bus.in_use_rs1 && tracked(bus.in_rs1);
   assign src2_act_s = bus.in_use_rs2 && tracked(bus.in_rs2);
   assign wb1_hit_s  = src1_act_s && bus.wb_valid && (bus.wb_rd == bus.in_rs1);
   assign wb2_hit_s  = src2_act_s && bus.wb_valid && (bus.wb_rd == bus.in_rs2);

`ifdef OPFETCH_BYPASS_EN
   // Writeback in flight resolves the dependency through the forward path
   assign src1_haz_s = src1_act_s && busy_s[0] && !wb1_hit_s;
   assign src2_haz_s = src2_act_s && busy_s[1] && !wb2_hit_s;
`else
   // Register file still shows the old value during writeback: wait a cycle
   assign src1_haz_s = src1_act_s && (busy_s[0] || wb1_hit_s);
   assign src2_haz_s = src2_act_s && (busy_s[1] || wb2_hit_s);
`endif

   assign waw_haz_s  = bus.in_rd_w && tracked(bus.in_rd) && busy_s[2];
   // The held op has not reached the scoreboard yet, so compare directly
   assign held_haz_s = out_valid_q && tracked(out_rd_q) &&
                       ((src1_act_s && (bus.in_rs1 == out_rd_q)) ||
                        (src2_act_s && (bus.in_rs2 == out_rd_q)) ||
                        (bus.in_rd_w && (bus.in_rd == out_rd_q)));
   assign hazard_s   = bus.in_valid && (src1_haz_s || src2_haz_s || waw_haz_s || held_haz_s);

   assign in_ready_s = !hazard_s && (!out_valid_q || bus.out_ready) && !bus.flush;
   assign accept_s   = bus.in_valid && in_ready_s;
   assign out_fire_s = out_valid_q && bus.out_ready && !bus.flush;

   assign bus.in_ready   = in_ready_s;
   assign bus.rf_rs1_sel = bus.in_rs1;
   assign bus.rf_rs2_sel = bus.in_rs2;
   assign bus.rf_rs1_en  = bus.in_valid && bus.in_use_rs1;
   assign bus.rf_rs2_en  = bus.in_valid && bus.in_use_rs2;

   assign bus.out_valid   = out_valid_q;
   assign bus.out_rs1_val = out_rs1_q;
   assign bus.out_rs2_val = out_rs2_q;
   assign bus.out_rd      = out_rd_q;

   opfetch_scoreboard u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en_i  (out_fire_s),
      .set_idx_i (out_rd_q),
      .clr_en_i  (bus.wb_valid),
      .clr_idx_i (bus.wb_rd),
      .q_idx_i   ({bus.in_rd, bus.in_rs2, bus.in_rs1}),
      .busy_o    (busy_s)
   );

   // Operand select: zero, forwarded writeback, or register-file data
   always_comb begin
      op1_s = {XLEN{1'b0}};
      op2_s = {XLEN{1'b0}};
      if (!src1_act_s) begin
         op1_s = {XLEN{1'b0}};
`ifdef OPFETCH_BYPASS_EN
      end else if (wb1_hit_s) begin
         op1_s = bus.wb_data;
`endif
      end else begin
         op1_s = bus.rf_rs1_data;
      end
      if (!src2_act_s) begin
         op2_s = {XLEN{1'b0}};
`ifdef OPFETCH_BYPASS_EN
      end else if (wb2_hit_s) begin
         op2_s = bus.wb_data;
`endif
      end else begin
         op2_s = bus.rf_rs2_data;
      end
   end

   // Output stage next state: flush kills, accept loads, handshake drains
   always_comb begin
      out_valid_d = out_valid_q;
      out_rs1_d   = out_rs1_q;
      out_rs2_d   = out_rs2_q;
      out_rd_d    = out_rd_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (accept_s) begin
         out_valid_d = 1'b1;
         out_rs1_d   = op1_s;
         out_rs2_d   = op2_s;
         out_rd_d    = bus.in_rd_w ? bus.in_rd : REG_ZERO;
      end else if (out_fire_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_rs1_q   <= {XLEN{1'b0}};
         out_rs2_q   <= {XLEN{1'b0}};
         out_rd_q    <= REG_ZERO;
      end else begin
         out_valid_q <= out_valid_d;
         out_rs1_q   <= out_rs1_d;
         out_rs2_q   <= out_rs2_d;
         out_rd_q    <= out_rd_d;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch. Expectations follow the
// OPFETCH_BYPASS_EN build option when it is defined.
module tb_operand_fetch;
   import riscv_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   operand_fetch_if bus ();

   operand_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      bus.in_valid    = 1'b0;
      bus.in_rs1      = 5'd0;
      bus.in_rs2      = 5'd0;
      bus.in_use_rs1  = 1'b0;
      bus.in_use_rs2  = 1'b0;
      bus.in_rd       = 5'd0;
      bus.in_rd_w     = 1'b0;
      bus.rf_rs1_data = 32'h0;
      bus.rf_rs2_data = 32'h0;
      bus.wb_valid    = 1'b0;
      bus.wb_rd       = 5'd0;
      bus.wb_data     = 32'h0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      @(negedge clk);
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%0h exp=0", bus.out_valid); end
      n_chk++; if (bus.out_rs1_val !== 32'h0) begin n_err++; $display("FAIL rst_rs1_val got=%0h exp=0", bus.out_rs1_val); end
      n_chk++; if (bus.out_rs2_val !== 32'h0) begin n_err++; $display("FAIL rst_rs2_val got=%0h exp=0", bus.out_rs2_val); end
      n_chk++; if (bus.out_rd !== 5'd0) begin n_err++; $display("FAIL rst_out_rd got=%0h exp=0", bus.out_rd); end
      n_chk++; if (dut.u_sb.busy_q !== 32'h0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", dut.u_sb.busy_q); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      @(negedge clk);
      idle();
      bus.in_valid = 1'b1; bus.in_rs1 = 5'd5; bus.in_rs2 = 5'd6;
      bus.in_use_rs1 = 1'b1; bus.in_use_rs2 = 1'b1;
      bus.in_rd = 5'd4; bus.in_rd_w = 1'b0;
      bus.rf_rs1_data = 32'h11; bus.rf_rs2_data = 32'h22;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready got=%0h exp=1", bus.in_ready); end
      n_chk++; if (bus.rf_rs1_sel !== 5'd5 || bus.rf_rs2_sel !== 5'd6) begin n_err++; $display("FAIL basic_rf_sel got=%0d/%0d exp=5/6", bus.rf_rs1_sel, bus.rf_rs2_sel); end
      n_chk++; if (bus.rf_rs1_en !== 1'b1 || bus.rf_rs2_en !== 1'b1) begin n_err++; $display("FAIL basic_rf_en got=%0b/%0b exp=1/1", bus.rf_rs1_en, bus.rf_rs2_en); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid got=%0h exp=1", bus.out_valid); end
      n_chk++; if (bus.out_rs1_val !== 32'h11) begin n_err++; $display("FAIL basic_rs1_val got=%0h exp=11", bus.out_rs1_val); end
      n_chk++; if (bus.out_rs2_val !== 32'h22) begin n_err++; $display("FAIL basic_rs2_val got=%0h exp=22", bus.out_rs2_val); end
      n_chk++; if (bus.out_rd !== 5'd0) begin n_err++; $display("FAIL basic_out_rd_nowrite got=%0d exp=0", bus.out_rd); end
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got=%0h exp=0", bus.out_valid); end
   endtask

   task automatic test_raw();
      @(negedge clk);
      idle();
      bus.in_valid = 1'b1; bus.in_rd = 5'd3; bus.in_rd_w = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd3) begin n_err++; $display("FAIL raw_producer got=%0b/%0d exp=1/3", bus.out_valid, bus.out_rd); end
      @(negedge clk);
      bus.in_rd = 5'd0; bus.in_rd_w = 1'b0;
      bus.in_rs1 = 5'd3; bus.in_use_rs1 = 1'b1; bus.rf_rs1_data = 32'h1234;
      #1;
      n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL raw_held_stall got=%0h exp=0", bus.in_ready); end
      @(posedge clk); #1;
      n_chk++; if (dut.u_sb.busy_q[3] !== 1'b1) begin n_err++; $display("FAIL raw_busy3_set got=%0h exp=1", dut.u_sb.busy_q[3]); end
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL raw_no_issue got=%0h exp=0", bus.out_valid); end
      @(negedge clk); #1;
      n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL raw_busy_stall got=%0h exp=0", bus.in_ready); end
      @(negedge clk);
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEADBEEF;
      #1;
`ifdef OPFETCH_BYPASS_EN
      n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL raw_wb_ready got=%0h exp=1", bus.in_ready); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rs1_val !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_bypass_val got=%0b/%0h exp=1/deadbeef", bus.out_valid, bus.out_rs1_val); end
      n_chk++; if (dut.u_sb.busy_q[3] !== 1'b0) begin n_err++; $display("FAIL raw_busy3_clr got=%0h exp=0", dut.u_sb.busy_q[3]); end
`else
      n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL raw_wb_ready got=%0h exp=0", bus.in_ready); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL raw_wb_noissue got=%0h exp=0", bus.out_valid); end
      n_chk++; if (dut.u_sb.busy_q[3] !== 1'b0) begin n_err++; $display("FAIL raw_busy3_clr got=%0h exp=0", dut.u_sb.busy_q[3]); end
      @(negedge clk);
      bus.wb_valid = 1'b0; bus.rf_rs1_data = 32'hDEADBEEF;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL raw_late_ready got=%0h exp=1", bus.in_ready); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rs1_val !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_late_val got=%0b/%0h exp=1/deadbeef", bus.out_valid, bus.out_rs1_val); end
`endif
      @(negedge clk);
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_zero();
      @(negedge clk);
      idle();
      bus.in_valid = 1'b1; bus.in_use_rs1 = 1'b1; bus.in_use_rs2 = 1'b1;
      bus.rf_rs1_data = 32'hFFFFFFFF; bus.rf_rs2_data = 32'hFFFFFFFF;
      bus.in_rd = 5'd0; bus.in_rd_w = 1'b1;
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hAAAA5555;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got=%0h exp=1", bus.in_ready); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_rs1_val !== 32'h0 || bus.out_rs2_val !== 32'h0) begin n_err++; $display("FAIL zero_vals got=%0h/%0h exp=0/0", bus.out_rs1_val, bus.out_rs2_val); end
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      n_chk++; if (dut.u_sb.busy_q !== 32'h0) begin n_err++; $display("FAIL zero_busy got=%0h exp=0", dut.u_sb.busy_q); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      idle();
      bus.in_valid = 1'b1; bus.in_rs1 = 5'd2; bus.in_use_rs1 = 1'b1; bus.rf_rs1_data = 32'h55;
      bus.in_rd = 5'd8; bus.in_rd_w = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rs1_val !== 32'h55) begin n_err++; $display("FAIL bp_first got=%0b/%0h exp=1/55", bus.out_valid, bus.out_rs1_val); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.in_rs1 = 5'd10; bus.in_rd = 5'd11; bus.rf_rs1_data = 32'h66;
         end
         #1;
         n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%0h exp=0", i, bus.in_ready); end
         @(posedge clk); #1;
         n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rs1_val !== 32'h55 || bus.out_rd !== 5'd8) begin n_err++; $display("FAIL bp_hold cyc=%0d got=%0b/%0h/%0d exp=1/55/8", i, bus.out_valid, bus.out_rs1_val, bus.out_rd); end
         n_chk++; if (dut.u_sb.busy_q[8] !== 1'b0) begin n_err++; $display("FAIL bp_busy_early cyc=%0d got=%0h exp=0", i, dut.u_sb.busy_q[8]); end
      end
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      n_chk++; if (dut.u_sb.busy_q[8] !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got=%0b/%0b exp=1/0", dut.u_sb.busy_q[8], bus.out_valid); end
      @(negedge clk);
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd8;
      @(negedge clk);
      idle();
      n_chk++; if (dut.u_sb.busy_q[8] !== 1'b0) begin n_err++; $display("FAIL bp_busy_clr got=%0h exp=0", dut.u_sb.busy_q[8]); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      idle();
      bus.in_valid = 1'b1; bus.in_rd = 5'd7; bus.in_rd_w = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd7) begin n_err++; $display("FAIL fl_held got=%0b/%0d exp=1/7", bus.out_valid, bus.out_rd); end
      @(negedge clk);
      bus.in_rd = 5'd0; bus.in_rd_w = 1'b0; bus.in_rs1 = 5'd12; bus.in_use_rs1 = 1'b1;
      bus.rf_rs1_data = 32'h12; bus.flush = 1'b1; bus.out_ready = 1'b1;
      #1;
      n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fl_no_accept got=%0h exp=0", bus.in_ready); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_out_valid got=%0h exp=0", bus.out_valid); end
      n_chk++; if (dut.u_sb.busy_q[7] !== 1'b0) begin n_err++; $display("FAIL fl_busy7 got=%0h exp=0", dut.u_sb.busy_q[7]); end
      @(negedge clk);
      bus.flush = 1'b0; bus.in_rs1 = 5'd7; bus.rf_rs1_data = 32'h77;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fl_reader_ready got=%0h exp=1", bus.in_ready); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rs1_val !== 32'h77) begin n_err++; $display("FAIL fl_reader_val got=%0b/%0h exp=1/77", bus.out_valid, bus.out_rs1_val); end
      @(negedge clk);
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_set_clear_reset();
      @(negedge clk);
      idle();
      bus.in_valid = 1'b1; bus.in_rd = 5'd9; bus.in_rd_w = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd9) begin n_err++; $display("FAIL sc_held got=%0b/%0d exp=1/9", bus.out_valid, bus.out_rd); end
      @(negedge clk);
      idle();
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd9;
      @(posedge clk); #1;
      n_chk++; if (dut.u_sb.busy_q[9] !== 1'b1) begin n_err++; $display("FAIL sc_set_wins got=%0h exp=1", dut.u_sb.busy_q[9]); end
      @(negedge clk);
      idle();
      bus.in_valid = 1'b1; bus.in_rd = 5'd13; bus.in_rd_w = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      bus.in_rd = 5'd0; bus.in_rd_w = 1'b0; bus.in_rs1 = 5'd9; bus.in_use_rs1 = 1'b1;
      #1;
      n_chk++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL sc_stall got=%0h exp=0", bus.in_ready); end
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++; if (bus.out_valid !== 1'b0 || bus.out_rd !== 5'd0) begin n_err++; $display("FAIL sc_rst_out got=%0b/%0d exp=0/0", bus.out_valid, bus.out_rd); end
      n_chk++; if (dut.u_sb.busy_q !== 32'h0) begin n_err++; $display("FAIL sc_rst_busy got=%0h exp=0", dut.u_sb.busy_q); end
      @(negedge clk);
      rst_n = 1'b1; bus.out_ready = 1'b1; bus.rf_rs1_data = 32'h99;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL sc_post_rst_ready got=%0h exp=1", bus.in_ready); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rs1_val !== 32'h99) begin n_err++; $display("FAIL sc_post_rst_val got=%0b/%0h exp=1/99", bus.out_valid, bus.out_rs1_val); end
      @(negedge clk);
      idle();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_raw();
      test_zero();
      test_backpressure();
      test_flush();
      test_set_clear_reset();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
